// File: rtl/rc522_scan_sequencer.sv
// rc522_scan_sequencer
// Walks an MFRC522 reader through a REQA and an ANTICOLL exchange using a
// one-outstanding register-access handshake, then publishes the 32-bit UID.
// Optional build macro: RFID_BCC_CHECK_EN -- when defined, the UID is only
// accepted if UID0^UID1^UID2^UID3 equals the received BCC byte.
module rc522_scan_sequencer #(
  parameter int POLL_MAX = 255,
  parameter int UID_BITS = 32
) (
  input  logic                clk_system,
  input  logic                reset_system,
  input  logic                start_scan,
  input  logic                abort,
  output logic                reg_req,
  output logic                reg_we,
  output logic [5:0]          reg_addr,
  output logic [7:0]          reg_wdata,
  input  logic                reg_ack,
  input  logic [7:0]          reg_rdata,
  output logic [UID_BITS-1:0] uid,
  output logic                uid_valid,
  output logic                busy,
  output logic                err,
  output logic [1:0]          err_code
);

  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LIMIT = PW'(POLL_MAX);

  // RC522 register addresses
  localparam logic [5:0] ADDR_COMMAND     = 6'h01;
  localparam logic [5:0] ADDR_FIFO_DATA   = 6'h09;
  localparam logic [5:0] ADDR_FIFO_LEVEL  = 6'h0A;
  localparam logic [5:0] ADDR_BIT_FRAMING = 6'h0D;

  // Without the BCC check the BCC byte is still read but never stored
`ifdef RFID_BCC_CHECK_EN
  localparam int RX_BYTES = 5;
`else
  localparam int RX_BYTES = 4;
`endif

  typedef enum logic [3:0] {
    IDLE, REQA_WR, REQA_POLL, REQA_RD, AC_WR, AC_POLL, AC_RD, CHECK, DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic            r_req;
  logic            r_we;
  logic [5:0]      r_addr;
  logic [7:0]      r_wdata;
  logic [2:0]      r_wr_idx;
  logic [2:0]      r_rd_cnt;
  logic [PW-1:0]   r_poll_cnt;
  logic            r_abort_lat;
  logic            r_busy;
  logic [1:0]      r_err_code;
  logic [31:0]     r_uid;
  logic            r_uid_valid;
  logic [7:0]      r_rx [RX_BYTES];

  logic            w_ack;
  logic            w_abort_pend;
  logic            w_access_state;
  logic            w_active;
  logic            w_abort_take;
  logic            w_wr_last;
  logic            w_rd_last;
  logic [7:0]      w_poll_thr;
  logic            w_poll_ok;
  logic [PW-1:0]   w_poll_cnt_inc;
  logic            w_poll_timeout;
  logic            w_bcc_ok;
  logic [31:0]     w_uid_word;
  logic            w_issue;
  logic            w_acc_we;
  logic [5:0]      w_acc_addr;
  logic [7:0]      w_acc_wdata;
  logic            w_err;

  // An ack only counts while our own request is outstanding
  assign w_ack          = reg_ack & r_req;
  assign w_abort_pend   = r_abort_lat | (abort & r_busy);
  assign w_access_state = (r_state == REQA_WR) || (r_state == REQA_POLL) ||
                          (r_state == REQA_RD) || (r_state == AC_WR) ||
                          (r_state == AC_POLL) || (r_state == AC_RD);
  assign w_active       = w_access_state || (r_state == CHECK);
  // Abort never cuts an access short: it waits for the ack if one is pending
  assign w_abort_take   = w_active & w_abort_pend & (~r_req | w_ack);

  assign w_wr_last      = ((r_state == REQA_WR) && (r_wr_idx == 3'd5)) ||
                          ((r_state == AC_WR)   && (r_wr_idx == 3'd6));
  assign w_rd_last      = ((r_state == REQA_RD) && (r_rd_cnt == 3'd1)) ||
                          ((r_state == AC_RD)   && (r_rd_cnt == 3'd4));
  assign w_poll_thr     = (r_state == AC_POLL) ? 8'd5 : 8'd2;
  assign w_poll_ok      = (reg_rdata >= w_poll_thr);
  assign w_poll_cnt_inc = r_poll_cnt + 1'b1;
  assign w_poll_timeout = ~w_poll_ok & (w_poll_cnt_inc == POLL_LIMIT);

  assign w_uid_word     = {r_rx[0], r_rx[1], r_rx[2], r_rx[3]};
`ifdef RFID_BCC_CHECK_EN
  assign w_bcc_ok       = ((r_rx[0] ^ r_rx[1] ^ r_rx[2] ^ r_rx[3]) == r_rx[4]);
`else
  assign w_bcc_ok       = 1'b1;
`endif

  assign reg_req   = r_req;
  assign reg_we    = r_we;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign uid       = UID_BITS'(r_uid);
  assign uid_valid = r_uid_valid;
  assign busy      = r_busy;
  assign err       = w_err;
  assign err_code  = r_err_code;

  // State register
  always_ff @(posedge clk_system or posedge reset_system) begin
    if (reset_system) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: phases advance only on acks of our own accesses
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (start_scan) w_state_next = REQA_WR;
      REQA_WR:   if (w_ack && w_wr_last) w_state_next = REQA_POLL;
      REQA_POLL: if (w_ack) begin
                   if (w_poll_ok) w_state_next = REQA_RD;
                   else if (w_poll_timeout) w_state_next = DONE;
                 end
      REQA_RD:   if (w_ack && w_rd_last) w_state_next = AC_WR;
      AC_WR:     if (w_ack && w_wr_last) w_state_next = AC_POLL;
      AC_POLL:   if (w_ack) begin
                   if (w_poll_ok) w_state_next = AC_RD;
                   else if (w_poll_timeout) w_state_next = DONE;
                 end
      AC_RD:     if (w_ack && w_rd_last) w_state_next = CHECK;
      CHECK:     w_state_next = DONE;
      DONE:      w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
    if (w_abort_take) w_state_next = DONE;
  end

  // Output logic: which register access the current state wants, and err
  always_comb begin
    w_acc_we    = 1'b0;
    w_acc_addr  = 6'h00;
    w_acc_wdata = 8'h00;
    case (r_state)
      REQA_WR: begin
        w_acc_we = 1'b1;
        case (r_wr_idx)
          3'd0:    begin w_acc_addr = ADDR_COMMAND;     w_acc_wdata = 8'h00; end
          3'd1:    begin w_acc_addr = ADDR_FIFO_LEVEL;  w_acc_wdata = 8'h80; end
          3'd2:    begin w_acc_addr = ADDR_BIT_FRAMING; w_acc_wdata = 8'h07; end
          3'd3:    begin w_acc_addr = ADDR_FIFO_DATA;   w_acc_wdata = 8'h26; end
          3'd4:    begin w_acc_addr = ADDR_COMMAND;     w_acc_wdata = 8'h0C; end
          default: begin w_acc_addr = ADDR_BIT_FRAMING; w_acc_wdata = 8'h87; end
        endcase
      end
      AC_WR: begin
        w_acc_we = 1'b1;
        case (r_wr_idx)
          3'd0:    begin w_acc_addr = ADDR_COMMAND;     w_acc_wdata = 8'h00; end
          3'd1:    begin w_acc_addr = ADDR_FIFO_LEVEL;  w_acc_wdata = 8'h80; end
          3'd2:    begin w_acc_addr = ADDR_BIT_FRAMING; w_acc_wdata = 8'h00; end
          3'd3:    begin w_acc_addr = ADDR_FIFO_DATA;   w_acc_wdata = 8'h93; end
          3'd4:    begin w_acc_addr = ADDR_FIFO_DATA;   w_acc_wdata = 8'h20; end
          3'd5:    begin w_acc_addr = ADDR_COMMAND;     w_acc_wdata = 8'h0C; end
          default: begin w_acc_addr = ADDR_BIT_FRAMING; w_acc_wdata = 8'h80; end
        endcase
      end
      REQA_POLL, AC_POLL: w_acc_addr = ADDR_FIFO_LEVEL;
      REQA_RD, AC_RD:     w_acc_addr = ADDR_FIFO_DATA;
      default: ;
    endcase
    // A pending abort blocks any new access from being launched
    w_issue = w_access_state & ~r_req & ~w_abort_pend;
    w_err   = (r_state == DONE) && (r_err_code != 2'd0);
  end

  // Register-access handshake: launch, hold until ack, drop the cycle after
  always_ff @(posedge clk_system or posedge reset_system) begin
    if (reset_system) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 6'h00;
      r_wdata <= 8'h00;
    end else if (w_ack) begin
      r_req <= 1'b0;
    end else if (w_issue) begin
      r_req   <= 1'b1;
      r_we    <= w_acc_we;
      r_addr  <= w_acc_addr;
      r_wdata <= w_acc_wdata;
    end
  end

  // Step counters: write index, read counter and per-phase poll count
  always_ff @(posedge clk_system or posedge reset_system) begin
    if (reset_system) begin
      r_wr_idx   <= 3'd0;
      r_rd_cnt   <= 3'd0;
      r_poll_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_wr_idx   <= 3'd0;
      r_rd_cnt   <= 3'd0;
      r_poll_cnt <= '0;
    end else if (w_ack) begin
      case (r_state)
        REQA_WR, AC_WR: begin
          if (w_wr_last) begin
            r_wr_idx   <= 3'd0;
            r_poll_cnt <= '0;
          end else begin
            r_wr_idx <= r_wr_idx + 3'd1;
          end
        end
        REQA_POLL, AC_POLL: begin
          if (w_poll_ok) r_rd_cnt <= 3'd0;
          else r_poll_cnt <= w_poll_cnt_inc;
        end
        REQA_RD, AC_RD: r_rd_cnt <= w_rd_last ? 3'd0 : r_rd_cnt + 3'd1;
        default: ;
      endcase
    end
  end

  // Capture the anticollision response bytes (UID0..UID3 and, if kept, BCC)
  always_ff @(posedge clk_system or posedge reset_system) begin
    if (reset_system) begin
      for (int i = 0; i < RX_BYTES; i++) r_rx[i] <= 8'h00;
    end else if ((r_state == AC_RD) && w_ack) begin
      for (int i = 0; i < RX_BYTES; i++) begin
        if (r_rd_cnt == 3'(i)) r_rx[i] <= reg_rdata;
      end
    end
  end

  // Abort latch: remembered while busy until it can take effect
  always_ff @(posedge clk_system or posedge reset_system) begin
    if (reset_system) begin
      r_abort_lat <= 1'b0;
    end else if ((r_state == IDLE) || (r_state == DONE) || w_abort_take) begin
      r_abort_lat <= 1'b0;
    end else if (abort && r_busy) begin
      r_abort_lat <= 1'b1;
    end
  end

  // Scan status: busy, error code and UID publication
  always_ff @(posedge clk_system or posedge reset_system) begin
    if (reset_system) begin
      r_busy      <= 1'b0;
      r_err_code  <= 2'd0;
      r_uid       <= 32'h0;
      r_uid_valid <= 1'b0;
    end else begin
      r_uid_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_scan) begin
            r_busy     <= 1'b1;
            r_err_code <= 2'd0;
          end
        end
        DONE: r_busy <= 1'b0;
        default: begin
          if (w_abort_take) begin
            r_err_code <= 2'd3;
          end else if (((r_state == REQA_POLL) || (r_state == AC_POLL)) &&
                       w_ack && w_poll_timeout) begin
            r_err_code <= 2'd1;
          end else if (r_state == CHECK) begin
            if (w_bcc_ok) begin
              r_uid       <= w_uid_word;
              r_uid_valid <= 1'b1;
            end else begin
              r_err_code <= 2'd2;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc522_scan_sequencer.sv
// Testbench for rc522_scan_sequencer: an RC522 register model answers each
// access after a programmable delay; expected accesses are queued per scan
// and compared as the DUT issues them.
`timescale 1ns/1ps
module tb_rc522_scan_sequencer;

  localparam int POLL_MAX = 4;
`ifdef RFID_BCC_CHECK_EN
  localparam bit BCC_EN = 1'b1;
`else
  localparam bit BCC_EN = 1'b0;
`endif

  logic        clk_system = 1'b0;
  logic        reset_system;
  logic        start_scan;
  logic        abort;
  logic        reg_req;
  logic        reg_we;
  logic [5:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_ack;
  logic [7:0]  reg_rdata;
  logic [31:0] uid;
  logic        uid_valid;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;

  rc522_scan_sequencer #(.POLL_MAX(POLL_MAX), .UID_BITS(32)) dut (
    .clk_system  (clk_system),
    .reset_system(reset_system),
    .start_scan  (start_scan),
    .abort       (abort),
    .reg_req     (reg_req),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_ack     (reg_ack),
    .reg_rdata   (reg_rdata),
    .uid         (uid),
    .uid_valid   (uid_valid),
    .busy        (busy),
    .err         (err),
    .err_code    (err_code)
  );

  always #5 clk_system = ~clk_system;

  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
  } acc_t;

  typedef struct {
    int          reqa_low;   // FIFOLevel reads below threshold in REQA
    logic [7:0]  reqa_lvl;   // level returned by those reads
    int          ac_low;     // FIFOLevel reads below threshold (level 4) in ANTICOLL
    logic [39:0] bytes;      // UID0..UID3, BCC
    bit          mid_start;  // pulse start_scan while busy
    bit          exp_upd;    // uid expected to update
    logic [1:0]  exp_code;
  } vec_t;

  acc_t        exp_q[$];
  logic [7:0]  lvl_q[$];
  logic [7:0]  data_q[$];
  int          checks = 0;
  int          errors = 0;
  int          acc_cnt = 0;
  int          ack_delay = 3;
  bit          stray_ack = 1'b0;
  int          uv_cnt = 0;
  int          err_cnt = 0;
  logic [1:0]  code_at_err = 2'd0;
  logic [31:0] exp_uid = 32'h0;
  vec_t        vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_acc(input logic we, input logic [5:0] addr, input logic [7:0] wdata);
    acc_t a;
    a.we = we; a.addr = addr; a.wdata = wdata;
    exp_q.push_back(a);
  endtask

  // Register model: checks each access against the scoreboard and acks it
  initial begin : responder
    bit   pending;
    int   wait_left;
    acc_t cur;
    acc_t ea;
    pending = 1'b0;
    wait_left = 0;
    reg_ack = 1'b0;
    reg_rdata = 8'h00;
    forever begin
      @(negedge clk_system);
      reg_ack = 1'b0;
      if (reset_system) begin
        pending = 1'b0;
      end else if (stray_ack) begin
        reg_ack = 1'b1;
        reg_rdata = 8'h5A;
        stray_ack = 1'b0;
      end else if (pending) begin
        if (wait_left == 0) begin
          checks++;
          if (reg_req !== 1'b1 || reg_we !== cur.we || reg_addr !== cur.addr ||
              reg_wdata !== cur.wdata) begin
            errors++;
            $display("FAIL hold_%0d: got req=%0b addr=0x%02h data=0x%02h, required req=1 addr=0x%02h data=0x%02h",
                     acc_cnt, reg_req, reg_addr, reg_wdata, cur.addr, cur.wdata);
          end
          if (!cur.we) begin
            if (cur.addr == 6'h0A) reg_rdata = (lvl_q.size() > 0) ? lvl_q.pop_front() : 8'h00;
            else reg_rdata = (data_q.size() > 0) ? data_q.pop_front() : 8'h00;
          end
          reg_ack = 1'b1;
          pending = 1'b0;
          $display("acc %0d: %s addr=0x%02h data=0x%02h", acc_cnt, cur.we ? "WR" : "RD",
                   cur.addr, cur.we ? cur.wdata : reg_rdata);
        end else begin
          wait_left--;
        end
      end else if (reg_req === 1'b1) begin
        cur.we = reg_we; cur.addr = reg_addr; cur.wdata = reg_wdata;
        acc_cnt++;
        pending = 1'b1;
        wait_left = ack_delay - 1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL access_extra: got we=%0b addr=0x%02h, required no access", reg_we, reg_addr);
        end else begin
          ea = exp_q.pop_front();
          if (reg_we !== ea.we || reg_addr !== ea.addr || (ea.we && reg_wdata !== ea.wdata)) begin
            errors++;
            $display("FAIL access_%0d: got we=%0b addr=0x%02h data=0x%02h, required we=%0b addr=0x%02h data=0x%02h",
                     acc_cnt, reg_we, reg_addr, reg_wdata, ea.we, ea.addr, ea.wdata);
          end
        end
      end
    end
  end

  // Pulse monitor
  initial begin : monitor
    forever begin
      @(negedge clk_system);
      if (uid_valid === 1'b1) uv_cnt++;
      if (err === 1'b1) begin
        err_cnt++;
        code_at_err = err_code;
      end
    end
  end

  // Fill model queues and the expected access list for one scan
  task automatic build_expect(input vec_t v);
    int n;
    lvl_q.delete(); data_q.delete(); exp_q.delete();
    push_acc(1, 6'h01, 8'h00); push_acc(1, 6'h0A, 8'h80); push_acc(1, 6'h0D, 8'h07);
    push_acc(1, 6'h09, 8'h26); push_acc(1, 6'h01, 8'h0C); push_acc(1, 6'h0D, 8'h87);
    n = (v.reqa_low >= POLL_MAX) ? POLL_MAX : v.reqa_low;
    for (int i = 0; i < n; i++) begin lvl_q.push_back(v.reqa_lvl); push_acc(0, 6'h0A, 8'h00); end
    if (v.reqa_low < POLL_MAX) begin
      lvl_q.push_back(8'd2); push_acc(0, 6'h0A, 8'h00);
      data_q.push_back(8'h04); data_q.push_back(8'h00);
      push_acc(0, 6'h09, 8'h00); push_acc(0, 6'h09, 8'h00);
      push_acc(1, 6'h01, 8'h00); push_acc(1, 6'h0A, 8'h80); push_acc(1, 6'h0D, 8'h00);
      push_acc(1, 6'h09, 8'h93); push_acc(1, 6'h09, 8'h20); push_acc(1, 6'h01, 8'h0C);
      push_acc(1, 6'h0D, 8'h80);
      n = (v.ac_low >= POLL_MAX) ? POLL_MAX : v.ac_low;
      for (int i = 0; i < n; i++) begin lvl_q.push_back(8'd4); push_acc(0, 6'h0A, 8'h00); end
      if (v.ac_low < POLL_MAX) begin
        lvl_q.push_back(8'd5); push_acc(0, 6'h0A, 8'h00);
        for (int i = 4; i >= 0; i--) begin
          data_q.push_back(v.bytes[i*8 +: 8]);
          push_acc(0, 6'h09, 8'h00);
        end
      end
    end
  endtask

  task automatic start_pulse();
    uv_cnt = 0; err_cnt = 0; code_at_err = 2'd0; acc_cnt = 0;
    @(negedge clk_system); start_scan = 1'b1;
    @(negedge clk_system); start_scan = 1'b0;
    chk("busy_rise", busy, 1);
    chk("err_code_clear", err_code, 0);
  endtask

  task automatic wait_idle(input string name, input bit mid_start);
    bit done;
    done = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_system);
      if (mid_start) start_scan = (cyc == 20);
      if (busy === 1'b0) begin done = 1'b1; break; end
    end
    start_scan = 1'b0;
    chk({name, "_finished"}, done, 1);
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("v%0d", idx);
    build_expect(v);
    if (v.exp_upd) exp_uid = v.bytes[39:8];
    start_pulse();
    wait_idle(nm, v.mid_start);
    chk({nm, "_accesses_left"}, 64'(exp_q.size()), 0);
    chk({nm, "_uid"}, uid, exp_uid);
    chk({nm, "_uid_valid_pulses"}, 64'(uv_cnt), v.exp_upd ? 1 : 0);
    chk({nm, "_err_pulses"}, 64'(err_cnt), (v.exp_code != 0) ? 1 : 0);
    chk({nm, "_err_code"}, err_code, v.exp_code);
    if (v.exp_code != 0) chk({nm, "_err_code_at_pulse"}, code_at_err, v.exp_code);
    chk({nm, "_req_idle"}, reg_req, 0);
    $display("vector %0d done: uid=0x%08h err_code=%0d accesses=%0d", idx, uid, err_code, acc_cnt);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t va;
    bit   seen;
    // BCC of DE AD BE EF is 0x22; 0x00 and 0xC2 are mismatches
    vecs[0] = '{0, 8'h00, 0, 40'hDEADBEEF22, 1'b0, 1'b1, 2'd0};
    vecs[1] = '{0, 8'h00, 0, 40'h1122334444, 1'b0, 1'b1, 2'd0};
    vecs[2] = '{0, 8'h00, 0, 40'hDEADBEEF00, 1'b0, !BCC_EN, BCC_EN ? 2'd2 : 2'd0};
    vecs[3] = '{0, 8'h00, 0, 40'hDEADBEEFC2, 1'b0, !BCC_EN, BCC_EN ? 2'd2 : 2'd0};
    vecs[4] = '{4, 8'h00, 0, 40'hDEADBEEF22, 1'b0, 1'b0, 2'd1};
    vecs[5] = '{3, 8'h01, 2, 40'h1234567808, 1'b1, 1'b1, 2'd0};
    vecs[6] = '{0, 8'h00, 4, 40'hA55A0FF000, 1'b0, 1'b0, 2'd1};
    vecs[7] = '{1, 8'h01, 1, 40'hA55A0FF000, 1'b0, 1'b1, 2'd0};

    reset_system = 1'b1; start_scan = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk_system);
    chk("reset_state", {reg_req, reg_we, reg_addr, reg_wdata, uid, uid_valid, busy, err, err_code}, 0);
    reset_system = 1'b0;
    @(negedge clk_system);

    for (int i = 0; i < 8; i++) run_vector(vecs[i], i);

    // Abort while the first ANTICOLL data read is outstanding (access 18)
    ack_delay = 5;
    va = vecs[0];
    build_expect(va);
    while (exp_q.size() > 18) void'(exp_q.pop_back());
    start_pulse();
    seen = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk_system);
      if (acc_cnt >= 18) begin seen = 1'b1; break; end
    end
    chk("abort_reached_ac_rd", seen, 1);
    abort = 1'b1;
    @(negedge clk_system);
    abort = 1'b0;
    chk("abort_req_held", reg_req, 1);
    wait_idle("abort", 1'b0);
    chk("abort_access_count", 64'(acc_cnt), 18);
    chk("abort_accesses_left", 64'(exp_q.size()), 0);
    chk("abort_err_code", err_code, 3);
    chk("abort_uid_valid_pulses", 64'(uv_cnt), 0);
    chk("abort_err_pulses", 64'(err_cnt), 1);
    chk("abort_uid", uid, exp_uid);
    $display("abort scenario done: err_code=%0d accesses=%0d", err_code, acc_cnt);

    // Reset in the middle of REQA_WR with an access outstanding
    ack_delay = 3;
    build_expect(vecs[0]);
    start_pulse();
    seen = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk_system);
      if (acc_cnt >= 3) begin seen = 1'b1; break; end
    end
    chk("reset_reached_wr", seen, 1);
    chk("reset_req_before", reg_req, 1);
    reset_system = 1'b1;
    #1;
    chk("reset_async_outputs", {reg_req, reg_we, reg_addr, reg_wdata, uid, uid_valid, busy, err, err_code}, 0);
    exp_uid = 32'h0;
    exp_q.delete();
    repeat (2) @(negedge clk_system);
    reset_system = 1'b0;
    stray_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_system);
      chk("late_ack_ignored", {reg_req, busy}, 0);
    end
    $display("reset scenario done: uid=0x%08h busy=%0b", uid, busy);
    run_vector(vecs[0], 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
